// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and source indices for the processor pipeline stages.
package pipeline_pkg;
    typedef enum logic [1:0] {LS_BYTE, LS_HALF, LS_WORD, LS_DWORD} load_size_t;
    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_PC4 = 2;
    localparam int SRC_IMM = 3;
    // Entry fields are sized for the widest supported configuration; stages keep only their low bits.
    localparam int ENTRY_DATA_W = 64;
    localparam int ENTRY_RD_W = 8;
    typedef struct packed {
        logic [ENTRY_DATA_W-1:0] data;
        logic [ENTRY_RD_W-1:0]   rd;
        logic                    we;
    } wb_entry_t;
endpackage

// File: rtl/load_aligner.sv
// load_aligner: selects the addressed byte/half/word lane of raw load data and sign/zero-extends it.
module load_aligner
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] raw,
    input  load_size_t      size,
    input  logic            isUnsigned,
    input  logic [2:0]      lsb,
    output logic [XLEN-1:0] ext
);
    localparam bit WIDE = XLEN == 64;
    logic [2:0] lane;
    logic [5:0] shAmt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic signBit;
    // On a 32-bit datapath a word (or dword) is the whole register, so its shift is always zero.
    always_comb begin
        lane = WIDE ? lsb : {1'b0, lsb[1:0]};
        shAmt = size == LS_BYTE ? {lane, 3'b000} :
                size == LS_HALF ? {lane[2:1], 4'b0000} :
                size == LS_WORD ? {WIDE & lane[2], 5'b00000} : 6'd0;
        shifted = raw >> shAmt;
        mask = size == LS_BYTE ? XLEN'(8'hFF) :
               size == LS_HALF ? XLEN'(16'hFFFF) :
               size == LS_WORD ? XLEN'(32'hFFFF_FFFF) : '1;
        signBit = size == LS_BYTE ? shifted[7] : size == LS_HALF ? shifted[15] : shifted[31];
        ext = (shifted & mask) | (!isUnsigned && signBit ? ~mask : '0);
    end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: result select, load alignment and a 2-entry skid FIFO in front of the register-file write port.
module writeback_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 4,
    parameter int MEM_SRC    = SRC_MEM,
    parameter int SEL_W      = $clog2(NUM_SRC)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_SRC*XLEN-1:0] src_data,
    input  logic [SEL_W-1:0]        wb_sel,
    input  logic [1:0]              load_size,
    input  logic                    load_unsigned,
    input  logic [2:0]              addr_lsb,
    input  logic [REG_ADDR_W-1:0]   rd,
    input  logic                    reg_write,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [XLEN-1:0]         wb_data,
    output logic [REG_ADDR_W-1:0]   wb_rd,
    output logic                    wb_we,
    output logic                    fwd_valid,
    output logic [REG_ADDR_W-1:0]   fwd_rd,
    output logic [XLEN-1:0]         fwd_data,
    output logic                    sel_err,
    output logic [31:0]             retire_cnt
);
    wb_entry_t headQ, tailQ, newEntry;
    logic [1:0] count;
    logic [XLEN-1:0] selData, loadData;
    logic selIllegal, push, pop;
    logic unusedEntryBits;

    load_aligner #(.XLEN(XLEN)) aligner (
        .raw       (src_data[MEM_SRC*XLEN +: XLEN]),
        .size      (load_size_t'(load_size)),
        .isUnsigned(load_unsigned),
        .lsb       (addr_lsb),
        .ext       (loadData)
    );

    always_comb begin
        selData = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (int'(wb_sel) == i) selData = src_data[i*XLEN +: XLEN];
    end

    // Illegal selects still occupy a slot so the pipe never loses a handshake.
    always_comb begin
        selIllegal = int'(wb_sel) >= NUM_SRC;
        newEntry = '0;
        newEntry.data = selIllegal ? '0 : ENTRY_DATA_W'(int'(wb_sel) == MEM_SRC ? loadData : selData);
        newEntry.rd = ENTRY_RD_W'(rd);
        newEntry.we = reg_write && rd != '0 && !selIllegal;
    end

    assign in_ready = count != 2'd2;
    assign wb_valid = count != 2'd0;
    assign push = in_valid && in_ready;
    assign pop = wb_valid && wb_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
            headQ <= '0;
            tailQ <= '0;
            sel_err <= 1'b0;
            retire_cnt <= '0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (push && (count == 2'd0 || (count == 2'd1 && pop))) headQ <= newEntry;
            else if (pop && count == 2'd2) headQ <= tailQ;
            if (push && count == 2'd1 && !pop) tailQ <= newEntry;
            if (push && selIllegal) sel_err <= 1'b1;
            if (pop && headQ.we) retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign wb_data = headQ.data[XLEN-1:0];
    assign wb_rd = headQ.rd[REG_ADDR_W-1:0];
    assign wb_we = headQ.we;
    assign fwd_valid = wb_valid && wb_we;
    assign fwd_rd = wb_rd;
    assign fwd_data = wb_data;
    assign unusedEntryBits = ^{headQ.data >> XLEN, headQ.rd >> REG_ADDR_W};
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors with a scoreboard queue checked by an independent pop monitor.
module tb_writeback_stage;
    logic        clk = 0;
    logic        reset = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [95:0] src_data = '0;
    logic [1:0]  wb_sel = '0;
    logic [1:0]  load_size = '0;
    logic        load_unsigned = 0;
    logic [2:0]  addr_lsb = '0;
    logic [4:0]  rd = '0;
    logic        reg_write = 0;
    logic        wb_valid;
    logic        wb_ready = 1;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        sel_err;
    logic [31:0] retire_cnt;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } exp_t;
    exp_t expQ[$];
    int checks = 0;
    int errors = 0;

    writeback_stage #(.XLEN(32), .REG_ADDR_W(5), .NUM_SRC(3), .MEM_SRC(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .src_data(src_data),
        .wb_sel(wb_sel), .load_size(load_size), .load_unsigned(load_unsigned), .addr_lsb(addr_lsb),
        .rd(rd), .reg_write(reg_write), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_we(wb_we), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .sel_err(sel_err), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: outputs are stable between edges, so a negedge with valid&ready is exactly one pop.
    always @(negedge clk) begin
        if (!reset && wb_valid && wb_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got rd %0d data 0x%08h, required no entry", wb_rd, wb_data);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                chk("pop_data", wb_data, e.data);
                chk("pop_rd", 32'(wb_rd), 32'(e.rd));
                chk("pop_we", 32'(wb_we), 32'(e.we));
                chk("fwd_valid", 32'(fwd_valid), 32'(e.we));
                chk("fwd_data", fwd_data, e.data);
            end
        end
    end

    always @(posedge reset) expQ.delete();

    task automatic send(input logic [1:0] sel, input logic [31:0] s0, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [1:0] sz, input bit uns, input logic [2:0] lsb,
                        input logic [4:0] r, input bit rw, input logic [31:0] expData, input bit expWe);
        int n = 0;
        exp_t e;
        in_valid = 1;
        wb_sel = sel;
        src_data = {s2, s1, s0};
        load_size = sz;
        load_unsigned = uns;
        addr_lsb = lsb;
        rd = r;
        reg_write = rw;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got in_ready 0, required 1 within 50 cycles");
        end else begin
            e.data = expData;
            e.rd = r;
            e.we = expWe;
            expQ.push_back(e);
            @(posedge clk);
            #1;
        end
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, required 0", expQ.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] MEMW = 32'h1234_80FF;

    initial begin
        #3;
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
        chk("rst_wb_we", 32'(wb_we), 0);
        chk("rst_fwd_valid", 32'(fwd_valid), 0);
        chk("rst_sel_err", 32'(sel_err), 0);
        chk("rst_retire", retire_cnt, 0);
        @(posedge clk);
        #1;
        reset = 0;
        @(posedge clk);
        #1;
        // Test 1: signed byte lane 1, one-cycle latency
        chk("t1_idle_valid", 32'(wb_valid), 0);
        send(2'd1, 32'h0, MEMW, 32'h0, 2'b00, 0, 3'd1, 5'd9, 1, 32'hFFFF_FF80, 1);
        chk("t1_latency_valid", 32'(wb_valid), 1);
        // Test 2: half/word alignment plus extra lanes
        send(2'd1, 32'h0, MEMW, 32'h0, 2'b01, 1, 3'd2, 5'd10, 1, 32'h0000_1234, 1);
        send(2'd1, 32'h0, MEMW, 32'h0, 2'b10, 0, 3'd3, 5'd11, 1, MEMW, 1);
        send(2'd1, 32'h0, MEMW, 32'h0, 2'b00, 1, 3'd0, 5'd12, 1, 32'h0000_00FF, 1);
        send(2'd1, 32'h0, MEMW, 32'h0, 2'b01, 0, 3'd1, 5'd13, 1, 32'hFFFF_80FF, 1);
        send(2'd1, 32'h0, MEMW, 32'h0, 2'b11, 0, 3'd6, 5'd14, 1, MEMW, 1);
        send(2'd0, 32'hCAFE_0001, MEMW, 32'h0, 2'b00, 0, 3'd1, 5'd15, 1, 32'hCAFE_0001, 1);
        send(2'd2, 32'h0, MEMW, 32'h0000_0104, 2'b00, 0, 3'd0, 5'd16, 0, 32'h0000_0104, 0);
        drain();
        chk("t2_retire", retire_cnt, 7);
        // Test 3: back-pressure with three back-to-back pushes
        pulse_reset();
        wb_ready = 0;
        send(2'd0, 32'h0000_0011, 32'h0, 32'h0, 2'b00, 0, 3'd0, 5'd1, 1, 32'h0000_0011, 1);
        chk("t3_ready_after1", 32'(in_ready), 1);
        send(2'd0, 32'h0000_0022, 32'h0, 32'h0, 2'b00, 0, 3'd0, 5'd2, 1, 32'h0000_0022, 1);
        chk("t3_ready_after2", 32'(in_ready), 0);
        chk("t3_head_rd_held", 32'(wb_rd), 1);
        fork
            send(2'd0, 32'h0000_0033, 32'h0, 32'h0, 2'b00, 0, 3'd0, 5'd3, 1, 32'h0000_0033, 1);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("t3_still_full", 32'(in_ready), 0);
                chk("t3_head_stable", wb_data, 32'h0000_0022 - 32'h11);
                wb_ready = 1;
            end
        join
        drain();
        chk("t3_retire", retire_cnt, 3);
        // Test 4: rd = 0 never writes or retires
        send(2'd0, 32'h0000_DEAD, 32'h0, 32'h0, 2'b00, 0, 3'd0, 5'd0, 1, 32'h0000_DEAD, 0);
        drain();
        chk("t4_retire", retire_cnt, 3);
        // Test 5: illegal select is sticky
        send(2'd3, 32'h1111_1111, MEMW, 32'h2222_2222, 2'b00, 0, 3'd0, 5'd8, 1, 32'h0, 0);
        drain();
        chk("t5_sel_err", 32'(sel_err), 1);
        send(2'd2, 32'h0, MEMW, 32'h0000_0200, 2'b00, 0, 3'd0, 5'd7, 1, 32'h0000_0200, 1);
        drain();
        chk("t5_sel_err_sticky", 32'(sel_err), 1);
        chk("t5_retire", retire_cnt, 4);
        // Test 6: async reset with two entries buffered
        wb_ready = 0;
        send(2'd0, 32'h0000_0005, 32'h0, 32'h0, 2'b00, 0, 3'd0, 5'd5, 1, 32'h0000_0005, 1);
        send(2'd0, 32'h0000_0006, 32'h0, 32'h0, 2'b00, 0, 3'd0, 5'd6, 1, 32'h0000_0006, 1);
        chk("t6_full", 32'(in_ready), 0);
        #2;
        reset = 1;
        #1;
        chk("t6_rst_valid", 32'(wb_valid), 0);
        chk("t6_rst_ready", 32'(in_ready), 1);
        chk("t6_rst_retire", retire_cnt, 0);
        chk("t6_rst_sel_err", 32'(sel_err), 0);
        chk("t6_rst_fwd", 32'(fwd_valid), 0);
        @(posedge clk);
        #1;
        reset = 0;
        wb_ready = 1;
        @(posedge clk);
        #1;
        send(2'd0, 32'h0000_0055, 32'h0, 32'h0, 2'b00, 0, 3'd0, 5'd4, 1, 32'h0000_0055, 1);
        drain();
        chk("t6_retire_after", retire_cnt, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
